// File: rtl/video_linebuf_out.sv
// Ping-pong line buffer and registered VGA pixel output stage.
// One 352-entry line is scanned out (each pixel shown twice) while the other
// is filled by the line renderer; buffers swap on every vnext pulse.
// Optional macro VIDEO_SCANLINES_EN: halve colour on odd output lines when
// scanlines=1. Without it the scanlines input is ignored.
module video_linebuf_out #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LINE_W = 352
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  input  logic              vnext,
  output logic              render_start,
  output logic [7:0]        render_line,
  input  logic              wr_en,
  input  logic [8:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  input  logic              scanlines,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [7:0]        underrun_cnt
);

  logic [DATA_W-1:0] mem0 [LINE_W];
  logic [DATA_W-1:0] mem1 [LINE_W];

  logic       sel_q, sel_d;
  logic       ready_q, ready_d;
  logic       pending_q, pending_d;
  logic       start_q, start_d;
  logic [7:0] line_q, line_d;
  logic [7:0] ur_q, ur_d;

  // Source line to render: two output lines ahead, wrapped at 262 line pairs.
  logic [10:0] t_sum, t_line;
  logic        req;
  assign t_sum  = ({1'b0, vpos} + 11'd3) >> 1;
  assign t_line = (t_sum >= 11'd262) ? (t_sum - 11'd262) : t_sum;
  assign req    = (t_line < 11'd240);

  // Swap/request/underrun bookkeeping; vnext overrides a coincident wr_done.
  always_comb begin
    sel_d     = sel_q;
    ready_d   = ready_q;
    pending_d = pending_q;
    start_d   = 1'b0;
    line_d    = line_q;
    ur_d      = ur_q;
    if (vnext) begin
      sel_d     = ~sel_q;
      ready_d   = 1'b0;
      pending_d = req;
      if (pending_q && !ready_q && (ur_q != 8'hFF)) ur_d = ur_q + 8'd1;
      if (req) begin
        start_d = 1'b1;
        line_d  = t_line[7:0];
      end
    end else if (wr_done) begin
      ready_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= 1'b0;
      ready_q   <= 1'b0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      line_q    <= 8'd0;
      ur_q      <= 8'd0;
    end else begin
      sel_q     <= sel_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      line_q    <= line_d;
      ur_q      <= ur_d;
    end
  end

  assign render_start = start_q;
  assign render_line  = line_q;
  assign underrun_cnt = ur_q;

  // Back-buffer writes; the active line length depends on mode.
  logic [8:0] wr_lim;
  logic       wr_ok;
  assign wr_lim = mode ? 9'd320 : 9'd352;
  assign wr_ok  = wr_en && (wr_addr < wr_lim);

  // Back buffer is the one not selected by sel_q.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (sel_q) mem0[wr_addr] <= wr_data;
      else       mem1[wr_addr] <= wr_data;
    end
  end

  // Front-buffer read, each source pixel covers two hpos values.
  logic [8:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pix_q;
  assign rd_addr = hpos[9:1];
  assign rd_data = (rd_addr >= 9'(LINE_W)) ? '0 : (sel_q ? mem1[rd_addr] : mem0[rd_addr]);

  // RAM output register, left unreset; blank masks it after reset.
  always_ff @(posedge clk) begin
    pix_q <= rd_data;
  end

  logic blank1_q, hs1_q, vs1_q;
  logic unused_sigs;
`ifdef VIDEO_SCANLINES_EN
  logic odd1_q;
  // Odd-line flag travels alongside the pixel for scanline dimming.
  always_ff @(posedge clk) begin
    if (reset) odd1_q <= 1'b0;
    else       odd1_q <= vpos[0];
  end
  assign unused_sigs = ^{hpos[0], t_line[10:8]};
`else
  assign unused_sigs = ^{hpos[0], t_line[10:8], scanlines};
`endif

  // First pipeline stage for blank and sync, matched to the RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank1_q <= 1'b1;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
    end else begin
      blank1_q <= blank;
      hs1_q    <= hsync;
      vs1_q    <= vsync;
    end
  end

  logic [3:0] r_d, g_d, b_d;
  // Colour selection: optional dimming, then forced black while blanked.
  always_comb begin
    r_d = pix_q[11:8];
    g_d = pix_q[7:4];
    b_d = pix_q[3:0];
`ifdef VIDEO_SCANLINES_EN
    if (scanlines && odd1_q) begin
      r_d = r_d >> 1;
      g_d = g_d >> 1;
      b_d = b_d >> 1;
    end
`endif
    if (blank1_q) begin
      r_d = 4'd0;
      g_d = 4'd0;
      b_d = 4'd0;
    end
  end

  // Registered VGA pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r     <= 4'd0;
      vga_g     <= 4'd0;
      vga_b     <= 4'd0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      vga_r     <= r_d;
      vga_g     <= g_d;
      vga_b     <= b_d;
      vga_hsync <= hs1_q;
      vga_vsync <= vs1_q;
    end
  end

endmodule

// File: tb/tb_video_linebuf_out.sv
// Self-checking bench for video_linebuf_out: vector tables, hand sequences
// and a randomised frame walk against a behavioural line-buffer model.
module tb_video_linebuf_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, mode, hsync, vsync, blank, vnext;
  logic [9:0] hpos, vpos;
  logic       render_start;
  logic [7:0] render_line, underrun_cnt;
  logic       wr_en, wr_done, scanlines;
  logic [8:0] wr_addr;
  logic [11:0] wr_data;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync;

  video_linebuf_out dut (
    .clk(clk), .reset(reset), .mode(mode), .hpos(hpos), .vpos(vpos),
    .hsync(hsync), .vsync(vsync), .blank(blank), .vnext(vnext),
    .render_start(render_start), .render_line(render_line),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .scanlines(scanlines), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .underrun_cnt(underrun_cnt)
  );

`ifdef VIDEO_SCANLINES_EN
  localparam bit ScanEn = 1'b1;
`else
  localparam bit ScanEn = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Behavioural model: two line arrays, a front index and request bookkeeping.
  int m_mem [2][352];
  bit m_val [2][352];
  int m_sel, m_ur, m_line;
  bit m_pend, m_ready;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int colour();
    return int'({vga_r, vga_g, vga_b});
  endfunction

  function automatic int req_line(input int v);
    int t;
    t = (v + 3) / 2;
    if (t >= 262) t -= 262;
    return (t < 240) ? t : -1;
  endfunction

  function automatic int exp_col(input int pix, input bit sc, input bit odd);
    int r, g, b;
    r = (pix >> 8) & 15;
    g = (pix >> 4) & 15;
    b = pix & 15;
    if (ScanEn && sc && odd) begin
      r /= 2; g /= 2; b /= 2;
    end
    return (r << 8) | (g << 4) | b;
  endfunction

  function automatic bit blank_of(input int h, input int v);
    return (h >= (mode ? 640 : 704)) || (v >= 480);
  endfunction

  function automatic bit hs_of(input int h);
    if (mode) return !(h >= 656 && h < 752);
    return !(h >= 746 && h < 796);
  endfunction

  function automatic bit vs_of(input int v);
    return !(v == 490 || v == 491);
  endfunction

  task automatic set_idle();
    blank = 1'b1; hsync = 1'b1; vsync = 1'b1; vnext = 1'b0;
    wr_en = 1'b0; wr_done = 1'b0; scanlines = 1'b0;
  endtask

  task automatic model_reset();
    m_sel = 0; m_ur = 0; m_line = 0; m_pend = 0; m_ready = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 352; a++) m_val[b][a] = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic pulse_vnext(input int v, input bit with_done, output int line);
    vpos = 10'(v); vnext = 1'b1; wr_done = with_done;
    tick();
    vnext = 1'b0; wr_done = 1'b0;
    m_sel = 1 - m_sel;
    if (m_pend && !m_ready && m_ur < 255) m_ur++;
    m_ready = 1'b0;
    line = req_line(v);
    m_pend = (line >= 0);
    if (line >= 0) m_line = line;
    check("req_start", int'(render_start), int'(line >= 0));
    check("req_line", int'(render_line), m_line);
    check("underrun", int'(underrun_cnt), m_ur);
    tick();
    check("start_width", int'(render_start), 0);
  endtask

  task automatic write_px(input int a, input int d);
    wr_en = 1'b1; wr_addr = 9'(a); wr_data = 12'(d);
    tick();
    wr_en = 1'b0;
    if (a < (mode ? 320 : 352)) begin
      m_mem[1 - m_sel][a] = d;
      m_val[1 - m_sel][a] = 1'b1;
    end
  endtask

  task automatic send_done();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    m_ready = 1'b1;
  endtask

  // Drive a run of hpos values and compare each output with the input two cycles back.
  task automatic scan(input int v, input int h0, input int h1, input bit sc);
    int ph; bit pb, phs, pvs;
    ph = 0; pb = 1'b1; phs = 1'b1; pvs = 1'b1;
    for (int h = h0; h <= h1; h++) begin
      hpos = 10'(h); vpos = 10'(v); blank = blank_of(h, v);
      hsync = hs_of(h); vsync = vs_of(v); scanlines = sc;
      tick();
      if (h > h0) begin
        check("scan_hsync", int'(vga_hsync), int'(phs));
        check("scan_vsync", int'(vga_vsync), int'(pvs));
        if (pb) check("scan_blank", colour(), 0);
        else if (ph / 2 < 352 && m_val[m_sel][ph / 2])
          check("scan_pix", colour(), exp_col(m_mem[m_sel][ph / 2], sc, v[0]));
      end
      ph = h; pb = blank; phs = hsync; pvs = vsync;
    end
  endtask

  task automatic hold_pixel(input int h, input int v, input bit blk, input bit sc);
    hpos = 10'(h); vpos = 10'(v); blank = blk; hsync = 1'b1; vsync = 1'b1;
    scanlines = sc;
    tick(); tick(); tick();
  endtask

  typedef struct {
    int v;
    int exp_start;
    int exp_line;
    int exp_ur;
  } req_vec_t;

  typedef struct {
    int pix;
    bit sc;
    bit odd;
    int exp;
  } pix_vec_t;

  int line, n_req, next_line;
  int outv [14];
  bit hs_got [6];

  initial begin
    req_vec_t rv [7];
    pix_vec_t pv [6];
    rv[0] = '{521, 1, 0, 0};
    rv[1] = '{523, 1, 1, 1};
    rv[2] = '{477, 0, 1, 2};
    rv[3] = '{475, 1, 239, 2};
    rv[4] = '{1, 1, 2, 3};
    rv[5] = '{1023, 0, 2, 4};
    rv[6] = '{999, 1, 239, 4};
    pv[0] = '{12'hFA6, 1'b1, 1'b0, 12'hFA6};
    pv[1] = '{12'hFA6, 1'b1, 1'b1, ScanEn ? 12'h753 : 12'hFA6};
    pv[2] = '{12'hFA6, 1'b0, 1'b1, 12'hFA6};
    pv[3] = '{12'h0F1, 1'b1, 1'b1, ScanEn ? 12'h070 : 12'h0F1};
    pv[4] = '{12'h888, 1'b1, 1'b1, ScanEn ? 12'h444 : 12'h888};
    pv[5] = '{12'hFFF, 1'b1, 1'b0, 12'hFFF};

    mode = 1'b0; hpos = '0; vpos = '0; wr_addr = '0; wr_data = '0;
    do_reset();
    check("rst_rgb", colour(), 0);
    check("rst_hsync", int'(vga_hsync), 1);
    check("rst_vsync", int'(vga_vsync), 1);
    check("rst_start", int'(render_start), 0);
    check("rst_line", int'(render_line), 0);
    check("rst_underrun", int'(underrun_cnt), 0);

    // Request computation table; no renderer answers, so underruns accumulate.
    for (int i = 0; i < 7; i++) begin
      vpos = 10'(rv[i].v); vnext = 1'b1;
      tick();
      vnext = 1'b0;
      check("tab_start", int'(render_start), rv[i].exp_start);
      check("tab_line", int'(render_line), rv[i].exp_line);
      check("tab_underrun", int'(underrun_cnt), rv[i].exp_ur);
    end

    // Scanline dimming table.
    do_reset();
    for (int i = 0; i < 6; i++) write_px(i, pv[i].pix);
    send_done();
    pulse_vnext(521, 1'b0, line);
    for (int i = 0; i < 6; i++) begin
      hold_pixel(2 * i, pv[i].odd ? 1 : 0, 1'b0, pv[i].sc);
      check("tab_pix", colour(), pv[i].exp);
    end

    // Full frame: renderer answers every request with random writes.
    do_reset();
    n_req = 0; next_line = 0;
    for (int k = 0; k < 262; k++) begin
      int v;
      v = (521 + 2 * k) % 524;
      pulse_vnext(v, 1'b0, line);
      if (line >= 0) begin
        check("frame_seq", line, next_line);
        next_line++; n_req++;
        for (int w = 0; w < 6; w++) write_px($urandom_range(0, 359), $urandom_range(0, 4095));
        send_done();
      end
      if (k % 50 == 10) scan((v + 1) % 525, 0, 799, 1'($urandom_range(0, 1)));
    end
    check("frame_pulses", n_req, 240);
    check("frame_underrun", int'(underrun_cnt), 0);

    // Line 0 filled with its own addresses, then scanned out.
    do_reset();
    pulse_vnext(521, 1'b0, line);
    for (int a = 0; a < 352; a++) write_px(a, a);
    send_done();
    pulse_vnext(523, 1'b0, line);
    for (int h = 0; h < 14; h++) begin
      hpos = 10'(h); vpos = '0; blank = 1'b0; hsync = 1'b1; vsync = 1'b1; scanlines = 1'b0;
      tick();
      outv[h] = colour();
    end
    check("lag_h11", outv[10], 4);
    check("lag_h12", outv[11], 5);
    check("lag_h13", outv[12], 5);
    check("lag_h14", outv[13], 6);
    scan(0, 0, 799, 1'b0);
    scan(1, 0, 799, 1'b1);
    for (int h = 744; h < 750; h++) begin
      hpos = 10'(h); vpos = '0; blank = blank_of(h, 0); hsync = hs_of(h); vsync = 1'b1;
      tick();
      hs_got[h - 744] = vga_hsync;
    end
    check("hsync_747", int'(hs_got[2]), 1);
    check("hsync_748", int'(hs_got[3]), 0);

    // Mode 1 drops writes at 320 and above; blank past 640.
    do_reset();
    write_px(330, 12'h0AB);
    write_px(10, 12'h111);
    pulse_vnext(1, 1'b0, line);
    scan(2, 600, 700, 1'b0);
    pulse_vnext(3, 1'b0, line);
    mode = 1'b1;
    write_px(330, 12'hFFF);
    write_px(10, 12'h222);
    pulse_vnext(5, 1'b0, line);
    mode = 1'b0;
    scan(6, 0, 703, 1'b0);
    hold_pixel(660, 6, 1'b0, 1'b0);
    check("mode1_drop", colour(), 12'h0AB);
    hold_pixel(20, 6, 1'b0, 1'b0);
    check("mode1_keep", colour(), 12'h222);
    mode = 1'b1;
    scan(6, 600, 720, 1'b0);
    hold_pixel(660, 6, 1'b1, 1'b0);
    check("mode1_blank", colour(), 0);
    mode = 1'b0;

    // Underrun counting, coincident wr_done, saturation.
    do_reset();
    pulse_vnext(7, 1'b0, line);
    check("ur_line5", int'(render_line), 5);
    pulse_vnext(9, 1'b0, line);
    check("ur_one", int'(underrun_cnt), 1);
    send_done();
    pulse_vnext(11, 1'b0, line);
    check("ur_answered", int'(underrun_cnt), 1);
    pulse_vnext(13, 1'b1, line);
    check("ur_coincide", int'(underrun_cnt), 2);
    pulse_vnext(15, 1'b0, line);
    check("ur_lost_done", int'(underrun_cnt), 3);
    for (int i = 0; i < 256; i++) pulse_vnext(9, 1'b0, line);
    check("ur_sat", int'(underrun_cnt), 255);

    // Reset mid-line coinciding with a vnext at vpos 100.
    hold_pixel(300, 100, 1'b0, 1'b0);
    hsync = 1'b0; vsync = 1'b0; vnext = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; vnext = 1'b0;
    model_reset();
    check("mid_rgb", colour(), 0);
    check("mid_hsync", int'(vga_hsync), 1);
    check("mid_vsync", int'(vga_vsync), 1);
    check("mid_start", int'(render_start), 0);
    check("mid_underrun", int'(underrun_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_req", int'(render_start), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
